// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the exact/approximate circuit evaluation harness.
// Holds the sweep FSM state encoding, drain length and the absolute-error helper.
package approx_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } eval_state_t;

    // Cycles spent after the last vector so both pipeline stages empty out.
    localparam int DRAIN_LEN = 2;

    // Operands are zero-extended to this width; callers cast the result back down.
    localparam int ABS_W = 32;

    function automatic logic [ABS_W-1:0] abs_err(input logic [ABS_W-1:0] a,
                                                 input logic [ABS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/approx_err_stage.sv
// Stage-1 register: magnitude of exact-minus-approx error, tagged with its vector.
// One cycle latency; no backpressure, a new vector is captured every enabled cycle.
module approx_err_stage
    import approx_eval_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [N_IN-1:0]  vec_i,
    input  logic [N_OUT-1:0] exact_i,
    input  logic [N_OUT-1:0] approx_i,
    output logic [N_OUT-1:0] diff_o,
    output logic [N_IN-1:0]  vec_o,
    output logic             v1_o
);

    logic [N_OUT-1:0] diff_q, diff_d;
    logic [N_IN-1:0]  vec_q;
    logic             v1_q;

    assign diff_d = N_OUT'(abs_err(ABS_W'(exact_i), ABS_W'(approx_i)));

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
            vec_q  <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= en_i;
            if (en_i) begin
                diff_q <= diff_d;
                vec_q  <= vec_i;
            end
        end
    end

    assign diff_o = diff_q;
    assign vec_o  = vec_q;
    assign v1_o   = v1_q;

endmodule

// File: rtl/approx_error_monitor.sv
// Sweeps all 2^N_IN vectors into an exact/approx circuit pair and scores the error.
// done arrives 2^N_IN+3 cycles after start; start is ignored while busy.
module approx_error_monitor
    import approx_eval_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  vec_out,
    input  logic [N_OUT-1:0] exact_in,
    input  logic [N_OUT-1:0] approx_in,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] max_err,
    output logic [N_IN:0]    err_count,
    output logic             fail_seen,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             pass
);

    // A threshold at or above the largest representable error can never be exceeded.
    localparam int               ET_MAX = (1 << N_OUT) - 1;
    localparam int               ET_EFF = (ET > ET_MAX) ? ET_MAX : ET;
    localparam logic [N_OUT-1:0] ET_V   = N_OUT'(ET_EFF);
    localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_LEN - 1);

    eval_state_t      state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [1:0]       drain_q, drain_d;
    logic [N_OUT-1:0] max_err_q, max_err_d;
    logic [N_IN:0]    err_cnt_q, err_cnt_d;
    logic             fail_q, fail_d;
    logic [N_IN-1:0]  first_q, first_d;
    logic             pass_q, pass_d;

    logic [N_OUT-1:0] s1_diff;
    logic [N_IN-1:0]  s1_vec;
    logic             s1_v;

    approx_err_stage #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q == ST_SWEEP),
        .vec_i    (vec_q),
        .exact_i  (exact_in),
        .approx_i (approx_in),
        .diff_o   (s1_diff),
        .vec_o    (s1_vec),
        .v1_o     (s1_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            drain_q   <= '0;
            max_err_q <= '0;
            err_cnt_q <= '0;
            fail_q    <= 1'b0;
            first_q   <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            drain_q   <= drain_d;
            max_err_q <= max_err_d;
            err_cnt_q <= err_cnt_d;
            fail_q    <= fail_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        drain_d   = drain_q;
        max_err_d = max_err_q;
        err_cnt_d = err_cnt_q;
        fail_d    = fail_q;
        first_d   = first_q;
        pass_d    = pass_q;

        // Stage 2: fold the registered error into the running results.
        if (s1_v) begin
            if (s1_diff > max_err_q) begin
                max_err_d = s1_diff;
            end
            if (s1_diff > ET_V) begin
                err_cnt_d = err_cnt_q + 1'b1;
                if (!fail_q) begin
                    fail_d  = 1'b1;
                    first_d = s1_vec;
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SWEEP;
                    vec_d     = '0;
                    max_err_d = '0;
                    err_cnt_d = '0;
                    fail_d    = 1'b0;
                    first_d   = '0;
                end
            end
            ST_SWEEP: begin
                // The counter parks on all-ones so the vector never wraps.
                if (vec_q == '1) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    pass_d  = (max_err_q <= ET_V);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vec_out        = vec_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign max_err        = max_err_q;
    assign err_count      = err_cnt_q;
    assign fail_seen      = fail_q;
    assign first_fail_vec = first_q;
    assign pass           = pass_q;

endmodule
